// File: rtl/cms_ctrl_axil_bridge.sv
// AXI4-Lite slave bridging host accesses onto the CMS control port.
// One outstanding access; write/read arbitration alternates when both are ready.
module cms_ctrl_axil_bridge #(
  parameter int CTRL_ADDR_WIDTH = 8,
  parameter int CTRL_DATA_WIDTH = 64,
  parameter int AXI_ADDR_WIDTH  = 12,
  parameter int LAST_CTRL_ADDR  = 22,
  parameter int RD_LATENCY      = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [AXI_ADDR_WIDTH-1:0]    s_axi_awaddr,
  input  logic                         s_axi_awvalid,
  output logic                         s_axi_awready,
  input  logic [CTRL_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [CTRL_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                         s_axi_wvalid,
  output logic                         s_axi_wready,
  output logic [1:0]                   s_axi_bresp,
  output logic                         s_axi_bvalid,
  input  logic                         s_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]    s_axi_araddr,
  input  logic                         s_axi_arvalid,
  output logic                         s_axi_arready,
  output logic [CTRL_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                   s_axi_rresp,
  output logic                         s_axi_rvalid,
  input  logic                         s_axi_rready,
  output logic [CTRL_ADDR_WIDTH-1:0]   ctrl_addr,
  output logic [CTRL_DATA_WIDTH-1:0]   ctrl_wdata,
  output logic                         ctrl_wr_en,
  output logic                         ctrl_rd_en,
  input  logic [CTRL_DATA_WIDTH-1:0]   ctrl_rdata
);

  localparam int AW = CTRL_ADDR_WIDTH;
  localparam int DW = CTRL_DATA_WIDTH;
  localparam int SW = DW / 8;
  localparam int LW = AW + 3;
  localparam logic [AW-1:0] LAST_A = AW'(LAST_CTRL_ADDR);
  localparam logic [2:0] LAT_M1 = 3'(RD_LATENCY - 1);
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE, WR_ISSUE, WR_RESP, RD_ISSUE, RD_WAIT, RD_RESP
  } state_t;

  state_t state;
  logic aw_held, w_held, ar_held, last_rd;
  logic [LW-1:0] aw_addr_q, ar_addr_q;
  logic [DW-1:0] w_data_q;
  logic [SW-1:0] w_strb_q;
  logic [2:0] lat_cnt;

  logic aw_hs, w_hs, ar_hs;
  logic [LW-1:0] aw_addr_e, ar_addr_e;
  logic [DW-1:0] w_data_e;
  logic [SW-1:0] w_strb_e;
  logic wr_pend, rd_pend, go_wr, go_rd;
  logic wr_ok, rd_ok;
  logic unused_addr;

  // Readies are only ever high in IDLE.
  assign aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_hs  = s_axi_wvalid & s_axi_wready;
  assign ar_hs = s_axi_arvalid & s_axi_arready;

  assign aw_addr_e = aw_held ? aw_addr_q : s_axi_awaddr[LW-1:0];
  assign ar_addr_e = ar_held ? ar_addr_q : s_axi_araddr[LW-1:0];
  assign w_data_e  = w_held ? w_data_q : s_axi_wdata;
  assign w_strb_e  = w_held ? w_strb_q : s_axi_wstrb;

  assign wr_pend = (aw_held | aw_hs) & (w_held | w_hs);
  assign rd_pend = ar_held | ar_hs;
  assign go_wr   = wr_pend & (~rd_pend | last_rd);
  assign go_rd   = rd_pend & ~go_wr;

  assign wr_ok = (aw_addr_e[2:0] == 3'b000) &&
                 (aw_addr_e[LW-1:3] <= LAST_A) &&
                 (&w_strb_e);
  assign rd_ok = (ar_addr_e[2:0] == 3'b000) &&
                 (ar_addr_e[LW-1:3] <= LAST_A);

  assign unused_addr = ^{s_axi_awaddr, s_axi_araddr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      ar_held       <= 1'b0;
      last_rd       <= 1'b1;
      aw_addr_q     <= '0;
      ar_addr_q     <= '0;
      w_data_q      <= '0;
      w_strb_q      <= '0;
      lat_cnt       <= '0;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_arready <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= OKAY;
      s_axi_rvalid  <= 1'b0;
      s_axi_rresp   <= OKAY;
      s_axi_rdata   <= '0;
      ctrl_addr     <= '0;
      ctrl_wdata    <= '0;
      ctrl_wr_en    <= 1'b0;
      ctrl_rd_en    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (aw_hs) begin
            aw_held   <= 1'b1;
            aw_addr_q <= s_axi_awaddr[LW-1:0];
          end
          if (w_hs) begin
            w_held   <= 1'b1;
            w_data_q <= s_axi_wdata;
            w_strb_q <= s_axi_wstrb;
          end
          if (ar_hs) begin
            ar_held   <= 1'b1;
            ar_addr_q <= s_axi_araddr[LW-1:0];
          end
          s_axi_awready <= ~(aw_held | aw_hs);
          s_axi_wready  <= ~(w_held | w_hs);
          s_axi_arready <= ~(aw_held | aw_hs | w_held | w_hs |
                             ar_held | ar_hs);
          if (go_wr) begin
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            last_rd       <= 1'b0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_arready <= 1'b0;
            if (wr_ok) begin
              state      <= WR_ISSUE;
              ctrl_wr_en <= 1'b1;
              ctrl_addr  <= aw_addr_e[LW-1:3];
              ctrl_wdata <= w_data_e;
            end else begin
              state        <= WR_RESP;
              s_axi_bvalid <= 1'b1;
              s_axi_bresp  <= SLVERR;
            end
          end else if (go_rd) begin
            ar_held       <= 1'b0;
            last_rd       <= 1'b1;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_arready <= 1'b0;
            if (rd_ok) begin
              state      <= RD_ISSUE;
              ctrl_rd_en <= 1'b1;
              ctrl_addr  <= ar_addr_e[LW-1:3];
            end else begin
              state        <= RD_RESP;
              s_axi_rvalid <= 1'b1;
              s_axi_rresp  <= SLVERR;
              s_axi_rdata  <= '0;
            end
          end
        end
        WR_ISSUE: begin
          ctrl_wr_en   <= 1'b0;
          s_axi_bvalid <= 1'b1;
          s_axi_bresp  <= OKAY;
          state        <= WR_RESP;
        end
        WR_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            state         <= IDLE;
            s_axi_awready <= ~aw_held;
            s_axi_wready  <= ~w_held;
            s_axi_arready <= ~(aw_held | w_held | ar_held);
          end
        end
        RD_ISSUE: begin
          ctrl_rd_en <= 1'b0;
          lat_cnt    <= LAT_M1;
          state      <= RD_WAIT;
        end
        RD_WAIT: begin
          if (lat_cnt == 3'd0) begin
            s_axi_rdata  <= ctrl_rdata;
            s_axi_rvalid <= 1'b1;
            s_axi_rresp  <= OKAY;
            state        <= RD_RESP;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        RD_RESP: begin
          if (s_axi_rready) begin
            s_axi_rvalid  <= 1'b0;
            state         <= IDLE;
            s_axi_awready <= ~aw_held;
            s_axi_wready  <= ~w_held;
            s_axi_arready <= ~(aw_held | w_held | ar_held);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
